alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one operation at a time, runs it on an external
// combinational ALU (add/nor/nori/not), rotates internally (rolv/rorv),
// compares internally (bleu), and holds the result until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer holds valid and payload until that edge. req_ready is 1
// only in IDLE. resp_valid is 1 only in RESP, and the payload stays frozen until
// resp_ready is seen.
module alu_sequencer #(
    parameter int ROT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_i1,
    output logic [31:0] alu_i2,
    output logic [4:0]  alu_sel,
    input  logic [31:0] alu_o,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_flag,
    output logic        resp_err,
    output logic [15:0] op_count,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] ROT  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [4:0] OP_ADD  = 5'b10000;
    localparam logic [4:0] OP_NOR  = 5'b10011;
    localparam logic [4:0] OP_NORI = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b00010;
    localparam logic [4:0] OP_BLEU = 5'b01000;
    localparam logic [4:0] OP_ROLV = 5'b00000;
    localparam logic [4:0] OP_RORV = 5'b00001;

    localparam logic [4:0] STEP = 5'(ROT_STEP);

    logic [1:0]  state_q, state_d;
    logic [4:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  rem_q;
    logic [31:0] result_q;
    logic        flag_q, err_q;
    logic [15:0] count_q;

    logic [4:0]  step;
    logic [4:0]  rem_next;
    logic [63:0] dbl_l, dbl_r;
    logic [31:0] rot_next;
    logic        op_is_alu, op_is_rot, op_legal;

    // Classify the incoming opcode for dispatch and error reporting.
    always_comb begin
        op_is_alu = (req_op == OP_ADD) || (req_op == OP_NOR) ||
                    (req_op == OP_NORI) || (req_op == OP_NOT);
        op_is_rot = (req_op == OP_ROLV) || (req_op == OP_RORV);
        op_legal  = op_is_alu || op_is_rot || (req_op == OP_BLEU);
    end

    // One rotation step: min(remaining, ROT_STEP) positions; the doubled word
    // makes a zero step fall out naturally as "no rotation".
    always_comb begin
        step     = (rem_q < STEP) ? rem_q : STEP;
        rem_next = rem_q - step;
        dbl_l    = {a_q, a_q} << step;
        dbl_r    = {a_q, a_q} >> step;
        rot_next = (op_q == OP_ROLV) ? dbl_l[63:32] : dbl_r[31:0];
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (op_is_alu)      state_d = EXEC;
                    else if (op_is_rot) state_d = ROT;
                    else                state_d = RESP;
                end
            end
            EXEC:    state_d = RESP;
            ROT:     if (rem_next == 5'd0) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand capture, result formation and the completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rem_q    <= 5'd0;
            result_q <= 32'd0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        a_q      <= req_a;
                        b_q      <= req_b;
                        rem_q    <= req_b[4:0];
                        result_q <= 32'd0;
                        flag_q   <= (req_op == OP_BLEU) && (req_a <= req_b);
                        err_q    <= !op_legal;
                    end
                end
                EXEC: result_q <= alu_o;
                ROT: begin
                    a_q   <= rot_next;
                    rem_q <= rem_next;
                    if (rem_next == 5'd0) result_q <= rot_next;
                end
                RESP: begin
                    if (resp_ready) count_q <= count_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // ALU drives are live only in EXEC; elsewhere they park at add 0 + 0.
    always_comb begin
        alu_sel = OP_ADD;
        alu_i1  = 32'd0;
        alu_i2  = 32'd0;
        if (state_q == EXEC) begin
            alu_sel = op_q;
            alu_i1  = a_q;
            alu_i2  = b_q;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_result = result_q;
    assign resp_flag   = flag_q;
    assign resp_err    = err_q;
    assign op_count    = count_q;
    assign dbg_state_o = state_q;

endmodule
